seq_alu_unit: RTL and testbench
===============================

Name: seq_alu_unit

Overview:
- Parametrised multi-cycle ALU execution unit for the next MiniAlu core generation.
- Executes ADD, SUB, unsigned MUL, signed MUL and compare-less-or-equal on WIDTH-bit operands.
- Multiplies use an iterative shift-add datapath instead of a combinational multiplier, and produce a 2*WIDTH-bit result.
- Sits between the register-file read stage and write-back; the core stalls instruction issue while oReady is low.

Parameters:
WIDTH, 16, operand width in bits (legal range 4..32); result width is 2*WIDTH.
CNT_W, 5, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
Clock  input  1  system clock, rising edge.
Reset  input  1  asynchronous, active-low reset.
iValid  input  1  operation request; sampled only while oReady=1.
oReady  output  1  unit idle, can accept a request this cycle.
iOperation  input  3  0=ADD, 1=SUB, 2=UMUL, 3=SMUL, 4=CMPLE, 5..7 illegal.
iA  input  WIDTH  source operand 0.
iB  input  WIDTH  source operand 1.
oResult  output  2*WIDTH  result; holds its value until the next completion.
oFlag  output  1  ADD: carry out; SUB: borrow (iA<iB unsigned); CMPLE: compare true; MUL: 0.
oError  output  1  completed operation had an illegal opcode.
oDone  output  1  one-cycle pulse; oResult, oFlag and oError are valid from this cycle.

Behaviour:
- Reset (Reset=0, asynchronous):
  - State goes to IDLE immediately.
  - oResult=0, oFlag=0, oError=0, oDone=0, oReady=1.
  - Counter and internal accumulator registers are cleared.
- States: IDLE, MUL, FIX.
- Acceptance: a request is accepted on the rising edge where iValid=1 and oReady=1 (state IDLE). iA, iB and iOperation are registered at that edge.
- iValid while oReady=0 is ignored. Requests are not queued.
- Single-cycle ops (ADD, SUB, CMPLE, illegal):
  - State stays in IDLE.
  - Results are registered at the acceptance edge, so oDone=1 in the following cycle (latency 1).
- ADD:
  - oResult = zero-extended WIDTH+1-bit sum.
  - oFlag = sum bit WIDTH.
- SUB:
  - oResult = iA - iB, sign-extended to 2*WIDTH bits.
  - oFlag = 1 when iA < iB unsigned.
- CMPLE:
  - oResult = 1 if iB <= iA (unsigned), else 0.
  - oFlag = same value.
- Illegal opcode: oResult=0, oFlag=0, oError=1.
- oError=0 for every legal opcode completion.
- UMUL/SMUL:
  - Acceptance edge: go to MUL and load the counter with WIDTH.
  - SMUL: operands are replaced by their magnitudes and the sign is recorded as the XOR of the MSBs.
  - MUL state, each cycle: if multiplier LSB=1, add the multiplicand into the upper half of the accumulator; then shift right one bit; counter decrements.
  - Counter reaching 0 moves the state to FIX.
  - FIX, one cycle: negate the accumulator if the SMUL sign is set, load oResult and pulse oDone.
  - oDone is high in cycle WIDTH+2 after the acceptance edge.
- Magnitude of -2**(WIDTH-1) is handled as a WIDTH+1-bit unsigned value, so SMUL of the most-negative operand is exact.
- oReady:
  - Low in MUL and FIX.
  - Goes high at the same edge oDone rises, so a back-to-back request can be accepted in the oDone cycle.
  - oDone of the previous op still pulses exactly once.
- Asynchronous reset asserted mid-multiply aborts the operation: no oDone, and oResult returns to 0.
- Outputs are registered. No combinational path from inputs to oResult, oFlag, oError or oDone. oReady is decoded from the state register.

Test Plan:
1. Reset, then ADD iA=16'hFFFF, iB=16'h0001 -> one cycle later oDone=1, oResult=32'h0001_0000, oFlag=1.
2. SUB iA=2, iB=5 -> oResult=32'hFFFF_FFFD, oFlag=1. CMPLE iA=7, iB=7 -> oResult=1, oFlag=1.
3. UMUL 16'hFFFF*16'hFFFF -> oReady low for 17 cycles, oDone in cycle 18 after acceptance, oResult=32'hFFFE_0001.
4. SMUL -3 (16'hFFFD) * 5 -> oResult=32'hFFFF_FFF1. SMUL 16'h8000*16'h8000 -> oResult=32'h4000_0000.
5. Hold iValid=1 during a multiply with a different op -> ignored. Issue ADD 1+1 in the oDone cycle -> accepted, next cycle oResult=2.
6. Drive Reset=0 at iteration 8 of a UMUL -> oReady=1 and oResult=0 immediately, no oDone. Then illegal opcode 7 -> oDone with oError=1, oResult=0.

Source files
------------

// File: rtl/seq_alu_unit_if.sv
// Request/result bundle between the register-read stage and the multi-cycle ALU.
// Handshake: a request is taken on the rising edge where iValid=1 and oReady=1; oDone pulses one cycle when oResult/oFlag/oError update.
interface seq_alu_unit_if #(
  parameter int WIDTH = 16
);
  logic                 iValid;
  logic                 oReady;
  logic [2:0]           iOperation;
  logic [WIDTH-1:0]     iA;
  logic [WIDTH-1:0]     iB;
  logic [2*WIDTH-1:0]   oResult;
  logic                 oFlag;
  logic                 oError;
  logic                 oDone;

  modport master (
    output iValid, iOperation, iA, iB,
    input  oReady, oResult, oFlag, oError, oDone
  );

  modport slave (
    input  iValid, iOperation, iA, iB,
    output oReady, oResult, oFlag, oError, oDone
  );
endinterface

// File: rtl/seq_alu_unit.sv
// Multi-cycle ALU: single-cycle ADD/SUB/CMPLE, iterative shift-add UMUL/SMUL with a sign-fix cycle.
module seq_alu_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             Clock,
  input  logic             Reset,
  seq_alu_unit_if.slave    bus,
  output logic [1:0]       oDbgState
);

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_UMUL  = 3'd2;
  localparam logic [2:0] OP_SMUL  = 3'd3;
  localparam logic [2:0] OP_CMPLE = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t               state;
  state_t               stateNext;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH:0]       mcand;
  logic [2*WIDTH+1:0]   acc;
  logic                 negate;

  logic                 isSmul;
  logic                 isMul;
  logic [WIDTH:0]       addSum;
  logic [WIDTH:0]       subDiff;
  logic                 cmpLe;
  logic [WIDTH:0]       aMag;
  logic [WIDTH-1:0]     bMag;
  logic [WIDTH+1:0]     upperSum;
  logic [2*WIDTH-1:0]   product;

  assign isSmul  = (bus.iOperation == OP_SMUL);
  assign isMul   = (bus.iOperation == OP_UMUL) || isSmul;
  assign addSum  = {1'b0, bus.iA} + {1'b0, bus.iB};
  assign subDiff = {1'b0, bus.iA} - {1'b0, bus.iB};
  assign cmpLe   = (bus.iB <= bus.iA);

  // Multiplicand magnitude keeps WIDTH+1 bits so -2**(WIDTH-1) stays exact;
  // the multiplier magnitude never exceeds 2**(WIDTH-1) and fits in WIDTH bits.
  assign aMag = (isSmul && bus.iA[WIDTH-1]) ? ({(WIDTH+1){1'b0}} - {bus.iA[WIDTH-1], bus.iA})
                                            : {1'b0, bus.iA};
  assign bMag = (isSmul && bus.iB[WIDTH-1]) ? (~bus.iB + 1'b1) : bus.iB;

  assign upperSum = acc[2*WIDTH+1:WIDTH] + (acc[0] ? {1'b0, mcand} : {(WIDTH+2){1'b0}});
  assign product  = acc[2*WIDTH-1:0];

  assign bus.oReady = (state == IDLE);
  assign oDbgState  = state;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (bus.iValid && isMul) stateNext = MUL;
      MUL:     if (cnt <= CNT_W'(1)) stateNext = FIX;
      FIX:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt         <= '0;
      mcand       <= '0;
      acc         <= '0;
      negate      <= 1'b0;
      bus.oResult <= '0;
      bus.oFlag   <= 1'b0;
      bus.oError  <= 1'b0;
      bus.oDone   <= 1'b0;
    end else begin
      bus.oDone <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.iValid) begin
            case (bus.iOperation)
              OP_ADD: begin
                bus.oResult <= {{(WIDTH-1){1'b0}}, addSum};
                bus.oFlag   <= addSum[WIDTH];
                bus.oError  <= 1'b0;
                bus.oDone   <= 1'b1;
              end
              OP_SUB: begin
                bus.oResult <= {{WIDTH{subDiff[WIDTH-1]}}, subDiff[WIDTH-1:0]};
                bus.oFlag   <= subDiff[WIDTH];
                bus.oError  <= 1'b0;
                bus.oDone   <= 1'b1;
              end
              OP_UMUL, OP_SMUL: begin
                cnt    <= CNT_W'(WIDTH);
                mcand  <= aMag;
                acc    <= {{(WIDTH+2){1'b0}}, bMag};
                negate <= isSmul && (bus.iA[WIDTH-1] ^ bus.iB[WIDTH-1]);
              end
              OP_CMPLE: begin
                bus.oResult <= {{(2*WIDTH-1){1'b0}}, cmpLe};
                bus.oFlag   <= cmpLe;
                bus.oError  <= 1'b0;
                bus.oDone   <= 1'b1;
              end
              default: begin
                bus.oResult <= '0;
                bus.oFlag   <= 1'b0;
                bus.oError  <= 1'b1;
                bus.oDone   <= 1'b1;
              end
            endcase
          end
        end
        MUL: begin
          acc <= {1'b0, upperSum, acc[WIDTH-1:1]};
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          bus.oResult <= negate ? (~product + 1'b1) : product;
          bus.oFlag   <= 1'b0;
          bus.oError  <= 1'b0;
          bus.oDone   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu_unit.sv
// Bench for seq_alu_unit: directed scenarios plus randomized ops scored against an arithmetic reference model.
module tb_seq_alu_unit;

  localparam int W = 16;

  logic       Clock;
  logic       Reset;
  logic [1:0] dbg_state;

  seq_alu_unit_if #(.WIDTH(W)) bus ();

  seq_alu_unit #(.WIDTH(W), .CNT_W(5)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .bus       (bus),
    .oDbgState (dbg_state)
  );

  int num_checks = 0;
  int num_errors = 0;
  int done_count = 0;

  logic [2*W-1:0] exp_q[$];
  logic           exp_flag_q[$];
  logic           exp_err_q[$];

  // clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    num_checks++;
    if (obs !== exp) begin
      num_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model from the operation definitions
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [2*W-1:0] r, output logic f, output logic e);
    longint ua, ub, sa, sb, t;
    logic [W-1:0] d;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    r = '0; f = 1'b0; e = 1'b0;
    case (op)
      3'd0: begin t = ua + ub; r = 32'(t); f = (t > 65535); end
      3'd1: begin d = 16'(ua - ub); t = longint'($signed(d)); r = 32'(t); f = (ua < ub); end
      3'd2: r = 32'(ua * ub);
      3'd3: r = 32'(sa * sb);
      3'd4: begin f = (ub <= ua); r = {31'd0, f}; end
      default: e = 1'b1;
    endcase
  endfunction

  // scoreboard: every oDone must match the oldest outstanding expectation
  always @(negedge Clock) begin
    if (Reset && bus.oDone) begin
      done_count++;
      check("done_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        check("result", bus.oResult, exp_q.pop_front());
        check("flag", bus.oFlag, exp_flag_q.pop_front());
        check("error", bus.oError, exp_err_q.pop_front());
      end
    end
  end

  task automatic push_exp(input logic [2*W-1:0] r, input logic f, input logic e);
    exp_q.push_back(r);
    exp_flag_q.push_back(f);
    exp_err_q.push_back(e);
  endtask

  // driver: issue one op, then wait (bounded) for its completion and check timing
  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] er, input logic ef, input logic ee);
    int lat, low, d0, exp_lat;
    exp_lat = (op == 3'd2 || op == 3'd3) ? W + 2 : 1;
    @(negedge Clock);
    check({tag, "_ready"}, bus.oReady, 1);
    bus.iValid = 1'b1; bus.iOperation = op; bus.iA = a; bus.iB = b;
    @(posedge Clock);
    #1 bus.iValid = 1'b0;
    push_exp(er, ef, ee);
    d0 = done_count; lat = 0; low = 0;
    while (done_count == d0 && lat < 100) begin
      @(negedge Clock); #1;
      lat++;
      if (!bus.oReady) low++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_busy"}, 64'(low), 64'(exp_lat - 1));
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_ready"}, bus.oReady, 1);
    check({tag, "_result"}, bus.oResult, 0);
    check({tag, "_flag"}, bus.oFlag, 0);
    check({tag, "_error"}, bus.oError, 0);
    check({tag, "_done"}, bus.oDone, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  initial begin
    logic [2*W-1:0] mr;
    logic           mf, me;
    logic [2:0]     op;
    logic [W-1:0]   a, b;
    int             n, d0;

    bus.iValid = 1'b0; bus.iOperation = '0; bus.iA = '0; bus.iB = '0;
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    check_idle_reset("reset");
    Reset = 1'b1;

    // directed cases
    run_op("add_carry", 3'd0, 16'hFFFF, 16'h0001, 32'h0001_0000, 1'b1, 1'b0);
    run_op("sub_neg",   3'd1, 16'd2, 16'd5, 32'hFFFF_FFFD, 1'b1, 1'b0);
    run_op("cmple_eq",  3'd4, 16'd7, 16'd7, 32'd1, 1'b1, 1'b0);
    run_op("cmple_gt",  3'd4, 16'd6, 16'd7, 32'd0, 1'b0, 1'b0);
    run_op("umul_max",  3'd2, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0, 1'b0);
    run_op("smul_neg",  3'd3, 16'hFFFD, 16'd5, 32'hFFFF_FFF1, 1'b0, 1'b0);
    run_op("smul_min",  3'd3, 16'h8000, 16'h8000, 32'h4000_0000, 1'b0, 1'b0);
    run_op("smul_minp", 3'd3, 16'h8000, 16'h0001, 32'hFFFF_8000, 1'b0, 1'b0);

    // ignored request during multiply, then back-to-back ADD in the oDone cycle
    @(negedge Clock);
    bus.iValid = 1'b1; bus.iOperation = 3'd3; bus.iA = 16'hFFFD; bus.iB = 16'd5;
    @(posedge Clock);
    #1;
    push_exp(32'hFFFF_FFF1, 1'b0, 1'b0);
    d0 = done_count;
    bus.iOperation = 3'd0; bus.iA = 16'd3; bus.iB = 16'd4;
    n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (!bus.oDone && n < 100);
    check("b2b_mul_latency", 64'(n), 64'(W + 2));
    check("b2b_ready_in_done", bus.oReady, 1);
    bus.iA = 16'd1; bus.iB = 16'd1;
    push_exp(32'd2, 1'b0, 1'b0);
    @(posedge Clock);
    #1 bus.iValid = 1'b0;
    @(negedge Clock); #1;
    check("b2b_done_count", 64'(done_count - d0), 64'd2);
    @(negedge Clock); #1;
    check("b2b_no_extra_done", 64'(done_count - d0), 64'd2);

    // reset asserted mid-multiply aborts without completion
    @(negedge Clock);
    bus.iValid = 1'b1; bus.iOperation = 3'd2; bus.iA = 16'hFFFF; bus.iB = 16'hFFFF;
    @(posedge Clock);
    #1 bus.iValid = 1'b0;
    repeat (8) @(negedge Clock);
    check("abort_busy", bus.oReady, 0);
    #2 Reset = 1'b0;
    #1 check_idle_reset("abort");
    d0 = done_count;
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    repeat (25) @(negedge Clock);
    check("abort_no_done", 64'(done_count - d0), 64'd0);
    run_op("illegal7", 3'd7, 16'h1234, 16'h5678, 32'd0, 1'b0, 1'b1);

    // randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0: a = 16'hFFFF;
        1: a = 16'h8000;
        default: a = 16'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0: b = 16'h7FFF;
        1: b = 16'h0000;
        default: b = 16'($urandom);
      endcase
      model(op, a, b, mr, mf, me);
      run_op("rand", op, a, b, mr, mf, me);
    end

    repeat (3) @(negedge Clock);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
